// File: rtl/parity_error_corrector_if.sv
// ---------------------------------------------------------------------------
// parity_error_corrector_if
//   Block-level bus for the 2D-parity error corrector.
//   Input side : in_valid/in_ready handshake carrying the received 128-bit
//                block plus the row, top-column and bottom-column mismatch
//                vectors.
//   Output side: out_valid/out_ready handshake carrying the corrected block,
//                per-half status and the number of bits flipped.
//   master = upstream/downstream environment, slave = the corrector.
// ---------------------------------------------------------------------------
interface parity_error_corrector_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [15:0]  row_errors;
  logic [7:0]   top_errors;
  logic [7:0]   bottom_errors;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic [1:0]   top_status;
  logic [1:0]   bottom_status;
  logic [1:0]   corrected_bits;

  modport master (
    output in_valid, data_in, row_errors, top_errors, bottom_errors, out_ready,
    input  in_ready, out_valid, data_out, top_status, bottom_status, corrected_bits
  );

  modport slave (
    input  in_valid, data_in, row_errors, top_errors, bottom_errors, out_ready,
    output in_ready, out_valid, data_out, top_status, bottom_status, corrected_bits
  );
endinterface

// File: rtl/parity_error_corrector.sv
// ---------------------------------------------------------------------------
// parity_error_corrector
//   Classifies each 8-row half of a 16x8 received block from its row and
//   column parity mismatches, flips the single data bit where exactly one
//   row and one column disagree, and returns the block with status.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     clear_count   synchronous clear of err_count (wins over an increment)
//     err_count     saturating total of corrected data bits
//     bus (slave)   input/output handshakes, data, error vectors, status
//   Flow: IDLE -> CLASSIFY (1) -> SCAN (16 rows) -> OUTPUT.  The first
//   OUTPUT cycle registers the result; out_valid rises on the next edge.
// ---------------------------------------------------------------------------
module parity_error_corrector #(
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_count,
  output logic [CNT_W-1:0]          err_count,
  parity_error_corrector_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CLASSIFY, SCAN, OUTPUT} state_e;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_FIXED  = 2'b01;
  localparam logic [1:0] ST_PARITY = 2'b10;
  localparam logic [1:0] ST_UNCORR = 2'b11;

  state_e         state_q, state_d;
  logic [127:0]   data_q;
  logic [15:0]    row_err_q;
  logic [7:0]     top_err_q, bot_err_q;
  logic [1:0]     top_st_q, bot_st_q;
  logic [2:0]     top_col_q, bot_col_q;
  logic [3:0]     row_q;
  logic [127:0]   data_out_q;
  logic [1:0]     top_status_q, bottom_status_q, corr_q;
  logic           out_valid_q;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic           accept, load_out, release_out, fix_row;
  logic [1:0]     cur_st;
  logic [2:0]     cur_col;
  logic [1:0]     corr_d;
  logic [CNT_W:0] cnt_sum;

  function automatic logic [1:0] classify(input logic [7:0] rows, input logic [7:0] cols);
    int r, c;
    r = $countones(rows);
    c = $countones(cols);
    if (r == 0 && c == 0)      return ST_CLEAN;
    else if (r == 1 && c == 1) return ST_FIXED;
    else if (r + c == 1)       return ST_PARITY;
    else                       return ST_UNCORR;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [2:0] set_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.in_valid) state_d = CLASSIFY;
      CLASSIFY: state_d = SCAN;
      SCAN:     if (row_q == 4'd15) state_d = OUTPUT;
      OUTPUT:   if (out_valid_q && bus.out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---- outputs / control strobes ----
  always_comb begin
    bus.in_ready       = (state_q == IDLE);
    accept             = bus.in_valid && (state_q == IDLE);
    load_out           = (state_q == OUTPUT) && !out_valid_q;
    release_out        = (state_q == OUTPUT) && out_valid_q && bus.out_ready;
    bus.out_valid      = out_valid_q;
    bus.data_out       = data_out_q;
    bus.top_status     = top_status_q;
    bus.bottom_status  = bottom_status_q;
    bus.corrected_bits = corr_q;
    err_count          = err_cnt_q;
  end

  // Row counter's MSB selects the half being scanned.
  assign cur_st  = row_q[3] ? bot_st_q  : top_st_q;
  assign cur_col = row_q[3] ? bot_col_q : top_col_q;
  assign fix_row = (cur_st == ST_FIXED) && row_err_q[row_q];
  assign corr_d  = {1'b0, top_st_q == ST_FIXED} + {1'b0, bot_st_q == ST_FIXED};

  // Saturating accumulate: increment is at most 2, so any carry out of the
  // CNT_W-bit range means the true sum passed the maximum.
  assign cnt_sum = {1'b0, err_cnt_q} + (CNT_W+1)'(corr_d);
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear_count)   err_cnt_d = '0;
    else if (load_out) err_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  // ---- datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q          <= '0;
      row_err_q       <= '0;
      top_err_q       <= '0;
      bot_err_q       <= '0;
      top_st_q        <= ST_CLEAN;
      bot_st_q        <= ST_CLEAN;
      top_col_q       <= '0;
      bot_col_q       <= '0;
      row_q           <= '0;
      data_out_q      <= '0;
      top_status_q    <= ST_CLEAN;
      bottom_status_q <= ST_CLEAN;
      corr_q          <= '0;
      out_valid_q     <= 1'b0;
      err_cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          data_q    <= bus.data_in;
          row_err_q <= bus.row_errors;
          top_err_q <= bus.top_errors;
          bot_err_q <= bus.bottom_errors;
        end
        CLASSIFY: begin
          top_st_q  <= classify(row_err_q[7:0],  top_err_q);
          bot_st_q  <= classify(row_err_q[15:8], bot_err_q);
          top_col_q <= set_index(top_err_q);
          bot_col_q <= set_index(bot_err_q);
          row_q     <= '0;
        end
        SCAN: begin
          // {row, col} is exactly the flat bit index 8*row + col.
          if (fix_row) data_q[{row_q, cur_col}] <= ~data_q[{row_q, cur_col}];
          row_q <= row_q + 4'd1;  // wraps to 0 after row 15
        end
        OUTPUT: begin
          if (load_out) begin
            data_out_q      <= data_q;
            top_status_q    <= top_st_q;
            bottom_status_q <= bot_st_q;
            corr_q          <= corr_d;
            out_valid_q     <= 1'b1;
          end else if (release_out) begin
            out_valid_q     <= 1'b0;
          end
        end
        default: ;
      endcase
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_parity_error_corrector.sv
module tb_parity_error_corrector;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, out_ready, clear_count;
  logic [127:0] data_in;
  logic [15:0]  row_errors;
  logic [7:0]   top_errors, bottom_errors;
  logic [15:0]  err16;
  logic [1:0]   err2;

  parity_error_corrector_if ifa();
  parity_error_corrector_if ifb();

  assign ifa.in_valid = in_valid;     assign ifb.in_valid = in_valid;
  assign ifa.data_in = data_in;       assign ifb.data_in = data_in;
  assign ifa.row_errors = row_errors; assign ifb.row_errors = row_errors;
  assign ifa.top_errors = top_errors; assign ifb.top_errors = top_errors;
  assign ifa.bottom_errors = bottom_errors; assign ifb.bottom_errors = bottom_errors;
  assign ifa.out_ready = out_ready;   assign ifb.out_ready = out_ready;

  parity_error_corrector #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .clear_count(clear_count), .err_count(err16), .bus(ifa));
  parity_error_corrector #(.CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .clear_count(clear_count), .err_count(err2),  .bus(ifb));

  localparam logic [127:0] PAT = 128'h0123456789ABCDEF0123456789ABCDEF;

  int n_cmp = 0, n_err = 0;
  int cnt16 = 0, cnt2 = 0;
  logic [127:0] exp_d;
  logic [1:0]   exp_ts, exp_bs, exp_cb;
  int           lat;

  // Reference: each half is decided purely by how many rows and columns disagree.
  function automatic void model(input logic [127:0] d, input logic [15:0] re, input logic [7:0] te,
                                input logic [7:0] be, output logic [127:0] od, output logic [1:0] ts,
                                output logic [1:0] bs, output logic [1:0] cb);
    od = d; cb = 2'd0; ts = 2'd0; bs = 2'd0;
    for (int h = 0; h < 2; h++) begin
      int nr = 0, nc = 0, rr = 0, cc = 0;
      logic [7:0] cv;
      logic [1:0] st;
      cv = (h == 1) ? be : te;
      for (int i = 0; i < 8; i++) begin
        if (re[8*h+i]) begin nr++; rr = 8*h + i; end
        if (cv[i]) begin nc++; cc = i; end
      end
      if (nr == 0 && nc == 0) st = 2'd0;
      else if (nr == 1 && nc == 1) begin st = 2'd1; od[8*rr+cc] = ~od[8*rr+cc]; cb = cb + 2'd1; end
      else if (nr + nc == 1) st = 2'd2;
      else st = 2'd3;
      if (h == 0) ts = st; else bs = st;
    end
  endfunction

  function automatic void bump(input logic [1:0] cb, input bit clr);
    if (clr) begin cnt16 = 0; cnt2 = 0; end
    else begin
      cnt16 = cnt16 + int'(cb);
      cnt2  = (cnt2 + int'(cb) > 3) ? 3 : cnt2 + int'(cb);
    end
  endfunction

  // Drives one block and waits for out_valid, leaving out_ready low.
  task automatic send_block(input logic [127:0] d, input logic [15:0] re, input logic [7:0] te,
                            input logic [7:0] be, input bit clr, output int l);
    int w = 0;
    while (!ifa.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    data_in = d; row_errors = re; top_errors = te; bottom_errors = be; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    row_errors = 16'($urandom); top_errors = 8'($urandom); bottom_errors = 8'($urandom);
    l = 0;
    while (l < 40) begin
      @(posedge clk); #1; l++;
      if (clr && l == 17) clear_count = 1'b1;
      if (ifa.out_valid) break;
    end
    clear_count = 1'b0;
    n_cmp++;
    if (!ifa.out_valid) begin n_err++; $display("FAIL timeout: out_valid=%0b after %0d cycles, want 1", ifa.out_valid, l); l = -1; end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear_count = 1'b0;
    data_in = '0; row_errors = '0; top_errors = '0; bottom_errors = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", ifa.in_ready); end
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.data_out !== 128'h0) begin n_err++; $display("FAIL reset data_out: got %h want 0", ifa.data_out); end
    n_cmp++; if ({ifa.top_status, ifa.bottom_status, ifa.corrected_bits} !== 6'h0) begin n_err++;
      $display("FAIL reset status: got %b want 000000", {ifa.top_status, ifa.bottom_status, ifa.corrected_bits}); end
    n_cmp++; if (err16 !== 16'h0 || err2 !== 2'h0) begin n_err++; $display("FAIL reset err_count: got %h/%h want 0/0", err16, err2); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    send_block(PAT, 16'h0, 8'h0, 8'h0, 1'b0, lat);
    n_cmp++; if (lat != 18) begin n_err++; $display("FAIL clean latency: got %0d want 18", lat); end
    n_cmp++; if (ifa.data_out !== PAT) begin n_err++; $display("FAIL clean data: got %h want %h", ifa.data_out, PAT); end
    n_cmp++; if ({ifa.top_status, ifa.bottom_status, ifa.corrected_bits} !== 6'h0) begin n_err++;
      $display("FAIL clean status: got %b want 000000", {ifa.top_status, ifa.bottom_status, ifa.corrected_bits}); end
    n_cmp++; if (err16 !== 16'd0) begin n_err++; $display("FAIL clean err_count: got %0d want 0", err16); end
    release_out();
  endtask

  task automatic test_single_top();
    send_block(PAT, 16'h0004, 8'h20, 8'h00, 1'b0, lat);
    bump(2'd1, 1'b0);
    n_cmp++; if (ifa.data_out !== (PAT ^ (128'h1 << 21))) begin n_err++;
      $display("FAIL single data: got %h want %h", ifa.data_out, PAT ^ (128'h1 << 21)); end
    n_cmp++; if (ifa.top_status !== 2'b01 || ifa.bottom_status !== 2'b00) begin n_err++;
      $display("FAIL single status: got %b/%b want 01/00", ifa.top_status, ifa.bottom_status); end
    n_cmp++; if (ifa.corrected_bits !== 2'd1) begin n_err++; $display("FAIL single corrected_bits: got %0d want 1", ifa.corrected_bits); end
    n_cmp++; if (err16 !== 16'd1) begin n_err++; $display("FAIL single err_count: got %0d want 1", err16); end
    release_out();
  endtask

  task automatic test_dual_backpressure();
    logic [127:0] want;
    want = PAT ^ 128'h1 ^ (128'h1 << 79);
    send_block(PAT, 16'h0201, 8'h01, 8'h80, 1'b0, lat);
    bump(2'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.data_out !== want) begin n_err++;
        $display("FAIL stall%0d data: got v=%b %h want v=1 %h", i, ifa.out_valid, ifa.data_out, want); end
      n_cmp++; if ({ifa.top_status, ifa.bottom_status, ifa.corrected_bits} !== 6'b01_01_10) begin n_err++;
        $display("FAIL stall%0d status: got %b want 010110", i, {ifa.top_status, ifa.bottom_status, ifa.corrected_bits}); end
      n_cmp++; if (err16 !== 16'(cnt16)) begin n_err++; $display("FAIL stall%0d err_count: got %0d want %0d", i, err16, cnt16); end
      @(posedge clk); #1;
    end
    release_out();
    n_cmp++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin n_err++;
      $display("FAIL release handshake: got out_valid=%b in_ready=%b want 0/1", ifa.out_valid, ifa.in_ready); end
    n_cmp++; if (err16 !== 16'(cnt16)) begin n_err++; $display("FAIL release err_count: got %0d want %0d", err16, cnt16); end
    n_cmp++; if (ifa.data_out !== want) begin n_err++; $display("FAIL idle hold data: got %h want %h", ifa.data_out, want); end
  endtask

  task automatic test_parity_only();
    send_block(PAT, 16'h0003, 8'h00, 8'h10, 1'b0, lat);
    n_cmp++; if (ifa.top_status !== 2'b11 || ifa.bottom_status !== 2'b10) begin n_err++;
      $display("FAIL parity status: got %b/%b want 11/10", ifa.top_status, ifa.bottom_status); end
    n_cmp++; if (ifa.data_out !== PAT || ifa.corrected_bits !== 2'd0) begin n_err++;
      $display("FAIL parity data: got %h cb=%0d want %h cb=0", ifa.data_out, ifa.corrected_bits, PAT); end
    n_cmp++; if (err16 !== 16'(cnt16)) begin n_err++; $display("FAIL parity err_count: got %0d want %0d", err16, cnt16); end
    release_out();
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [127:0] d;
      logic [15:0] re;
      logic [7:0] te, be, cv;
      d = {$urandom, $urandom, $urandom, $urandom};
      re = '0; te = '0; be = '0;
      for (int h = 0; h < 2; h++) begin
        cv = '0;
        case ($urandom_range(0, 3))
          0: ;
          1: begin re[8*h + $urandom_range(0, 7)] = 1'b1; cv[$urandom_range(0, 7)] = 1'b1; end
          2: if ($urandom_range(0, 1) == 1) re[8*h + $urandom_range(0, 7)] = 1'b1; else cv[$urandom_range(0, 7)] = 1'b1;
          default: begin re[8*h +: 8] = 8'($urandom); cv = 8'($urandom); end
        endcase
        if (h == 0) te = cv; else be = cv;
      end
      model(d, re, te, be, exp_d, exp_ts, exp_bs, exp_cb);
      send_block(d, re, te, be, 1'b0, lat);
      bump(exp_cb, 1'b0);
      n_cmp++; if (lat != 18) begin n_err++; $display("FAIL rand%0d latency: got %0d want 18", it, lat); end
      n_cmp++; if (ifa.data_out !== exp_d) begin n_err++; $display("FAIL rand%0d data: got %h want %h", it, ifa.data_out, exp_d); end
      n_cmp++; if ({ifa.top_status, ifa.bottom_status, ifa.corrected_bits} !== {exp_ts, exp_bs, exp_cb}) begin n_err++;
        $display("FAIL rand%0d status: got %b want %b", it, {ifa.top_status, ifa.bottom_status, ifa.corrected_bits}, {exp_ts, exp_bs, exp_cb}); end
      n_cmp++; if (err16 !== 16'(cnt16) || err2 !== 2'(cnt2)) begin n_err++;
        $display("FAIL rand%0d err_count: got %0d/%0d want %0d/%0d", it, err16, err2, cnt16, cnt2); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      release_out();
    end
  endtask

  task automatic test_midscan_reset();
    int w = 0;
    while (!ifa.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    data_in = PAT; row_errors = 16'h0004; top_errors = 8'h20; bottom_errors = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);  // CLASSIFY + rows 0..6 done; row 7 is current
    #1;
    rst_n = 1'b0;
    #1;
    cnt16 = 0; cnt2 = 0;
    n_cmp++; if (ifa.out_valid !== 1'b0 || err16 !== 16'd0 || err2 !== 2'd0) begin n_err++;
      $display("FAIL midscan reset: got out_valid=%b err=%0d/%0d want 0/0/0", ifa.out_valid, err16, err2); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin n_err++;
      $display("FAIL post-reset idle: got in_ready=%b out_valid=%b want 1/0", ifa.in_ready, ifa.out_valid); end
    send_block(PAT, 16'h0100, 8'h00, 8'h04, 1'b0, lat);
    bump(2'd1, 1'b0);
    n_cmp++; if (lat != 18) begin n_err++; $display("FAIL post-reset latency: got %0d want 18", lat); end
    n_cmp++; if (ifa.data_out !== (PAT ^ (128'h1 << 66)) || ifa.bottom_status !== 2'b01) begin n_err++;
      $display("FAIL post-reset data: got %h bs=%b want %h bs=01", ifa.data_out, ifa.bottom_status, PAT ^ (128'h1 << 66)); end
    n_cmp++; if (err16 !== 16'd1) begin n_err++; $display("FAIL post-reset err_count: got %0d want 1", err16); end
    release_out();
  endtask

  task automatic test_saturation_clear();
    clear_count = 1'b1;
    @(posedge clk); #1;
    clear_count = 1'b0;
    bump(2'd0, 1'b1);
    n_cmp++; if (err16 !== 16'd0 || err2 !== 2'd0) begin n_err++; $display("FAIL idle clear: got %0d/%0d want 0/0", err16, err2); end
    for (int b = 0; b < 5; b++) begin
      logic [15:0] re;
      logic [7:0] te;
      re = '0; te = '0;
      re[$urandom_range(0, 7)] = 1'b1;
      te[$urandom_range(0, 7)] = 1'b1;
      send_block(PAT, re, te, 8'h00, b == 4, lat);
      bump(2'd1, b == 4);
      n_cmp++; if (err2 !== 2'(cnt2) || err16 !== 16'(cnt16)) begin n_err++;
        $display("FAIL sat block%0d err_count: got %0d/%0d want %0d/%0d", b, err2, err16, cnt2, cnt16); end
      repeat (2) begin @(posedge clk); #1; end
      n_cmp++; if (err2 !== 2'(cnt2)) begin n_err++; $display("FAIL sat block%0d hold: got %0d want %0d", b, err2, cnt2); end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_top();
    test_dual_backpressure();
    test_parity_only();
    test_random();
    test_midscan_reset();
    test_saturation_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
